// File: rtl/axis_pkt_fifo_if.sv
// axis_pkt_fifo_if: write/read handshake bundle for axis_pkt_fifo.
interface axis_pkt_fifo_if #(parameter int WIDTH = 32);
  logic wr_vld, wr_rdy, wr_last, rd_vld, rd_rdy, rd_last;
  logic [WIDTH-1:0] wr_data, rd_data;
  modport master (output wr_vld, wr_data, wr_last, rd_rdy, input wr_rdy, rd_vld, rd_data, rd_last);
  modport slave (input wr_vld, wr_data, wr_last, rd_rdy, output wr_rdy, rd_vld, rd_data, rd_last);
endinterface

// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo: single-clock FIFO storing a last flag per word, cut-through or store-and-forward.
module axis_pkt_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int PKT_MODE = 0,
  parameter int AFULL_TH = DEPTH - 2,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  axis_pkt_fifo_if.slave s,
  output logic [AW:0] level,
  output logic [AW:0] pkt_cnt,
  output logic almost_full,
  output logic pkt_ovf
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF = (AW+1)'(AFULL_TH);
  logic [WIDTH:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q, level_d, pkt_cnt_q, pkt_cnt_d;
  logic pkt_ovf_q, pkt_ovf_d, wr_acc, rd_acc, full, empty;
  always_comb begin
    full = level_q == FULL;
    empty = level_q == '0;
    s.wr_rdy = !full;
    // full term lets a packet longer than DEPTH drain instead of deadlocking
    s.rd_vld = !empty && (PKT_MODE == 0 || pkt_cnt_q != '0 || full);
    {s.rd_last, s.rd_data} = empty ? '0 : mem[rd_ptr_q];
    wr_acc = s.wr_vld && !full && !clear;
    rd_acc = s.rd_vld && s.rd_rdy && !clear;
    wr_ptr_d = clear ? '0 : wr_ptr_q + AW'(wr_acc);
    rd_ptr_d = clear ? '0 : rd_ptr_q + AW'(rd_acc);
    level_d = clear ? '0 : level_q + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
    pkt_cnt_d = clear ? '0 : pkt_cnt_q + (AW+1)'(wr_acc && s.wr_last) - (AW+1)'(rd_acc && s.rd_last);
    pkt_ovf_d = PKT_MODE != 0 && !clear && (pkt_ovf_q || (level_d == FULL && pkt_cnt_d == '0));
    level = level_q;
    pkt_cnt = pkt_cnt_q;
    almost_full = level_q >= AF;
    pkt_ovf = pkt_ovf_q;
  end
  always_ff @(posedge clk)
    if (wr_acc) mem[wr_ptr_q] <= {s.wr_last, s.wr_data};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      pkt_cnt_q <= '0;
      pkt_ovf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
      pkt_cnt_q <= pkt_cnt_d;
      pkt_ovf_q <= pkt_ovf_d;
    end
endmodule

// File: tb/tb_axis_pkt_fifo.sv
// tb_axis_pkt_fifo: directed scoreboard bench for cut-through and store-and-forward instances.
module tb_axis_pkt_fifo;
  logic clk = 0, rst = 0, clr0 = 0, clr1 = 0;
  logic [3:0] lvl0, pc0, lvl1, pc1;
  logic af0, ovf0, af1, ovf1;
  logic [8:0] q0[$], q1[$];
  int total = 0, bad = 0;
  axis_pkt_fifo_if #(.WIDTH(8)) b0();
  axis_pkt_fifo_if #(.WIDTH(8)) b1();
  axis_pkt_fifo #(.WIDTH(8), .DEPTH(8), .PKT_MODE(0)) u0 (.clk(clk), .rst(rst), .clear(clr0), .s(b0),
    .level(lvl0), .pkt_cnt(pc0), .almost_full(af0), .pkt_ovf(ovf0));
  axis_pkt_fifo #(.WIDTH(8), .DEPTH(8), .PKT_MODE(1)) u1 (.clk(clk), .rst(rst), .clear(clr1), .s(b1),
    .level(lvl1), .pkt_cnt(pc1), .almost_full(af1), .pkt_ovf(ovf1));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    if (b0.rd_vld && b0.rd_rdy && !clr0) begin
      if (q0.size() == 0) chk("u0 sb empty", 0, 1);
      else chk("u0 rd", {23'd0, b0.rd_last, b0.rd_data}, {23'd0, q0.pop_front()});
    end
    if (b1.rd_vld && b1.rd_rdy && !clr1) begin
      if (q1.size() == 0) chk("u1 sb empty", 0, 1);
      else chk("u1 rd", {23'd0, b1.rd_last, b1.rd_data}, {23'd0, q1.pop_front()});
    end
    if (b0.wr_vld && b0.wr_rdy && !clr0) q0.push_back({b0.wr_last, b0.wr_data});
    if (b1.wr_vld && b1.wr_rdy && !clr1) q1.push_back({b1.wr_last, b1.wr_data});
    @(posedge clk);
    #1;
    if (clr0) q0.delete();
    if (clr1) q1.delete();
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    {b0.wr_vld, b0.wr_last, b0.rd_rdy, b1.wr_vld, b1.wr_last, b1.rd_rdy} = '0;
    b0.wr_data = 0;
    b1.wr_data = 0;
    #1 rst = 1;
    cyc();
    cyc();
    rst = 0;
    chk("rst wr_rdy", b0.wr_rdy, 1);
    chk("rst rd_vld", b0.rd_vld, 0);
    chk("rst rd_data", b0.rd_data, 0);
    chk("rst rd_last", b0.rd_last, 0);
    chk("rst level", lvl0, 0);
    chk("rst af", af0, 0);
    chk("rst ovf1", ovf1, 0);
    // fill to full
    b0.wr_vld = 1;
    for (int i = 0; i < 8; i++) begin
      b0.wr_data = 8'h11 + 8'(i);
      chk("fill af", af0, i >= 6);
      chk("fill level", lvl0, i);
      cyc();
    end
    b0.wr_vld = 0;
    chk("full wr_rdy", b0.wr_rdy, 0);
    chk("full level", lvl0, 8);
    chk("full af", af0, 1);
    b0.wr_vld = 1;
    b0.wr_data = 8'hAA;
    cyc();
    b0.wr_vld = 0;
    chk("full refuse level", lvl0, 8);
    b0.rd_rdy = 1;
    for (int i = 0; i < 8; i++) cyc();
    b0.rd_rdy = 0;
    chk("drain rd_vld", b0.rd_vld, 0);
    chk("drain rd_data", b0.rd_data, 0);
    chk("drain sb", q0.size(), 0);
    // streaming across pointer wrap
    b0.wr_vld = 1;
    b0.wr_data = 8'h40;
    cyc();
    b0.rd_rdy = 1;
    for (int i = 1; i <= 20; i++) begin
      b0.wr_data = 8'h40 + 8'(i);
      cyc();
      chk("stream level", lvl0, 1);
    end
    b0.wr_vld = 0;
    cyc();
    b0.rd_rdy = 0;
    chk("stream end level", lvl0, 0);
    chk("stream sb", q0.size(), 0);
    // store-and-forward: 3-word packet
    b1.wr_vld = 1;
    for (int i = 0; i < 3; i++) begin
      b1.wr_data = 8'h21 + 8'(i);
      b1.wr_last = i == 2;
      chk("saf hold", b1.rd_vld, 0);
      cyc();
    end
    b1.wr_vld = 0;
    b1.wr_last = 0;
    chk("saf vld", b1.rd_vld, 1);
    chk("saf pkt_cnt", pc1, 1);
    b1.rd_rdy = 1;
    for (int i = 0; i < 3; i++) cyc();
    b1.rd_rdy = 0;
    chk("saf pkt_cnt end", pc1, 0);
    chk("saf sb", q1.size(), 0);
    // store-and-forward overflow
    b1.wr_vld = 1;
    for (int i = 0; i < 8; i++) begin
      b1.wr_data = 8'h31 + 8'(i);
      cyc();
    end
    b1.wr_vld = 0;
    chk("ovf set", ovf1, 1);
    chk("ovf vld", b1.rd_vld, 1);
    chk("ovf wr_rdy", b1.wr_rdy, 0);
    b1.rd_rdy = 1;
    cyc();
    b1.rd_rdy = 0;
    chk("ovf wr_rdy back", b1.wr_rdy, 1);
    chk("ovf sticky", ovf1, 1);
    chk("ovf vld held", b1.rd_vld, 0);
    chk("ovf u0 tied", ovf0, 0);
    clr1 = 1;
    cyc();
    clr1 = 0;
    chk("ovf cleared", ovf1, 0);
    chk("ovf clr level", lvl1, 0);
    // clear with level 5, pkt_cnt 2, concurrent write
    b0.wr_vld = 1;
    for (int i = 0; i < 5; i++) begin
      b0.wr_data = 8'h51 + 8'(i);
      b0.wr_last = i == 1 || i == 4;
      cyc();
    end
    chk("pre clr level", lvl0, 5);
    chk("pre clr pkt", pc0, 2);
    clr0 = 1;
    b0.wr_data = 8'hEE;
    b0.wr_last = 0;
    cyc();
    clr0 = 0;
    b0.wr_vld = 0;
    chk("clr level", lvl0, 0);
    chk("clr pkt", pc0, 0);
    chk("clr rd_vld", b0.rd_vld, 0);
    chk("clr rd_data", b0.rd_data, 0);
    b0.wr_vld = 1;
    b0.wr_data = 8'h77;
    b0.wr_last = 1;
    cyc();
    b0.wr_vld = 0;
    b0.wr_last = 0;
    chk("post clr data", b0.rd_data, 8'h77);
    chk("post clr level", lvl0, 1);
    b0.rd_rdy = 1;
    cyc();
    b0.rd_rdy = 0;
    // asynchronous reset mid-burst
    b0.wr_vld = 1;
    for (int i = 0; i < 4; i++) begin
      b0.wr_data = 8'h61 + 8'(i);
      cyc();
    end
    b0.wr_vld = 0;
    chk("pre rst level", lvl0, 4);
    #2 rst = 1;
    #1;
    chk("async level", lvl0, 0);
    chk("async rd_vld", b0.rd_vld, 0);
    chk("async rd_data", b0.rd_data, 0);
    chk("async wr_rdy", b0.wr_rdy, 1);
    q0.delete();
    q1.delete();
    #2 rst = 0;
    b0.wr_vld = 1;
    b0.wr_data = 8'h99;
    cyc();
    b0.wr_vld = 0;
    chk("post rst data", b0.rd_data, 8'h99);
    chk("post rst level", lvl0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
